// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR latch driver: FSM state encoding and feedback match helper.
// Used by sr_latch_driver and by anything that observes its state for coverage.
// No ports; constants and one pure function only.
package sr_drv_pkg;

  // FSM state encoding (3-bit)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PULSE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Feedback comparison results
  localparam logic FB_MATCH    = 1'b1;
  localparam logic FB_MISMATCH = 1'b0;

  // The latch holds the requested value only when q equals it and q_dot is its
  // complement; q == q_dot (both driven or both released) is never a match.
  function automatic logic fb_match(input logic qs, input logic qds, input logic val);
    return ((qs == val) && (qds == ~val)) ? FB_MATCH : FB_MISMATCH;
  endfunction

endpackage

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchronizer for one asynchronous level signal.
// Latency: 2 clock edges from d to q; reset_n clears both stages to 0.
// Ports: clock, reset_n (async active-low), d (async in), q (synchronized out).
module sync2 (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Drives a cross-coupled SR latch: width-controlled, mutually exclusive s/r pulses,
// synchronized q/q_dot readback, bounded retries, done/err completion pulse.
// Latency: done P+S+4 cycles after handshake (1 if already matching), +P+S+3 per retry.
// Backpressure: req_ready high only in IDLE; requests outside IDLE are ignored.
// Ports: clock, reset_n, req_valid/req_ready/req_value (request), s/r (latch drive),
//        q_fb/q_dot_fb (async readback), done/err (completion).
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 2,
  parameter int CNT_W         = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_value,
  output logic s,
  output logic r,
  input  logic q_fb,
  input  logic q_dot_fb,
  output logic done,
  output logic err
);

  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic             qs;
  logic             qds;

  logic [2:0]       state_q, state_d;
  logic             val_q, val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  sync2 u_sync_q (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (q_fb),
    .q       (qs)
  );

  sync2 u_sync_qd (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (q_dot_fb),
    .q       (qds)
  );

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          val_d   = req_value;
          retry_d = '0;
          // Already holding the requested value: complete without pulsing.
          if (fb_match(qs, qds, req_value) == FB_MATCH) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_PULSE;
            cnt_d   = CNT_W'(PULSE_CYCLES - 1);
          end
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          // Settle window also covers the two synchronizer stages.
          cnt_d   = CNT_W'(SETTLE_CYCLES + 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (fb_match(qs, qds, val_q) == FB_MATCH) begin
          state_d = ST_DONE;
        end else if (retry_q < RTY_W'(MAX_RETRY)) begin
          retry_d = retry_q + RTY_W'(1);
          state_d = ST_PULSE;
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
        end else begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs registered from the next state so they line up with state_q.
    // s and r share one PULSE term gated by opposite polarities of val, so
    // they can never be high together.
    s_d     = (state_d == ST_PULSE) && val_d;
    r_d     = (state_d == ST_PULSE) && !val_d;
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      val_q   <= 1'b0;
      cnt_q   <= '0;
      retry_q <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      s_q     <= s_d;
      r_q     <= r_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign done      = done_q;
  assign err       = err_q;
  assign req_ready = ready_q;

endmodule
